// File: rtl/mux6_arb_pkg.sv
// Shared definitions for the six-port bus arbiter: port count, pointer width,
// beat counter width, FSM state encoding and the round-robin pointer advance.
// No logic of its own; imported by rr_pick6 and mux6_bus_arbiter.
package mux6_arb_pkg;

   localparam int NPORT = 6;
   localparam int PTR_W = 3;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Pointer advance past the last winner, wrapping 5 -> 0 so the pointer
   // never leaves the legal 0..5 range.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] w);
      if (w == PTR_W'(NPORT - 1)) begin
         return '0;
      end
      return w + 1'b1;
   endfunction

endpackage

// File: rtl/mux6_bus_arbiter_rr_pick6.sv
// Six-way winner picker: first set request scanning upward from a start port.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when the pick is used.
//   req    in  6  request vector
//   ptr    in  3  round-robin start port (0..5), ignored when mode=1
//   mode   in  1  0 = start scan at ptr, 1 = fixed priority (start at port 0)
//   onehot out 6  one-hot winner, all zero when req is zero
//   idx    out 3  binary index of the winner, zero when req is zero
module rr_pick6
   import mux6_arb_pkg::*;
(
   input  logic [NPORT-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   input  logic             mode,
   output logic [NPORT-1:0] onehot,
   output logic [PTR_W-1:0] idx
);

   // One extra bit so start + offset (max 5 + 5) does not overflow before the wrap.
   logic [PTR_W:0] start;
   logic [PTR_W:0] cand;
   logic           found;

   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      cand   = '0;
      start  = mode ? '0 : {1'b0, ptr};
      for (int i = 0; i < NPORT; i++) begin
         cand = start + (PTR_W+1)'(i);
         if (cand >= (PTR_W+1)'(NPORT)) begin
            cand = cand - (PTR_W+1)'(NPORT);
         end
         if (!found && req[cand[PTR_W-1:0]]) begin
            found                   = 1'b1;
            onehot[cand[PTR_W-1:0]] = 1'b1;
            idx                     = cand[PTR_W-1:0];
         end
      end
   end

endmodule

// File: rtl/mux6_bus_arbiter.sv
// Shares one DW-bit bus among six requesters with req/gnt handshake, burst grants
// and a one-cycle turnaround gap. Latency: req in cycle N -> gnt in cycle N+1.
// Backpressure: out_ready low holds the grant and beat count; source holds its data.
//   clk       in  1        rising-edge clock
//   rst_n     in  1        asynchronous active-low reset, synchronous release
//   req       in  6        per-port request, held while the port has beats
//   last      in  6        per-port end-of-burst marker, only the winner's counts
//   din       in  6*DW     packed source data, port k at din[k*DW +: DW]
//   gnt       out 6        registered one-hot grant
//   out_data  out DW       din of the granted port, zero when nothing granted
//   out_valid out 1        granted port is still requesting: beat on the bus
//   out_ready in  1        downstream accepts the beat when out_valid is high
//   busy      out 1        registered, high while granting and during the gap
// BURST must lie in 1..15 (4-bit beat counter); PRIO_MODE 0 = round-robin,
// 1 = fixed priority with port 0 highest.
module mux6_bus_arbiter
   import mux6_arb_pkg::*;
#(
   parameter int DW        = 4,
   parameter int BURST     = 4,
   parameter int PRIO_MODE = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NPORT-1:0]    req,
   input  logic [NPORT-1:0]    last,
   input  logic [NPORT*DW-1:0] din,
   output logic [NPORT-1:0]    gnt,
   output logic [DW-1:0]       out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                busy
);

   localparam logic FIXED = (PRIO_MODE != 0);

   state_t           state;
   state_t           state_d;
   logic [NPORT-1:0] gnt_d;
   logic             busy_d;
   logic [CNT_W-1:0] beat_cnt;
   logic [CNT_W-1:0] beat_cnt_d;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] rr_ptr_d;
   // Binary index of the current winner, kept alongside the one-hot grant so the
   // pointer update does not need an encoder on the gnt register.
   logic [PTR_W-1:0] win_idx;
   logic [PTR_W-1:0] win_idx_d;

   logic [NPORT-1:0] pick_onehot;
   logic [PTR_W-1:0] pick_idx;

   logic             grant_req;
   logic             grant_last;
   logic             beat;
   logic             burst_full;
   logic             end_grant;

   // The picker only matters in IDLE; its result is ignored in other states,
   // which is what makes the arbiter non-preemptive.
   rr_pick6 u_pick (
      .req    (req),
      .ptr    (rr_ptr),
      .mode   (FIXED),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   // Winner-qualified views of the request and last vectors; last on any
   // other port is masked out here.
   assign grant_req  = |(gnt & req);
   assign grant_last = |(gnt & last);
   assign out_valid  = grant_req;
   assign beat       = out_valid & out_ready;
   assign burst_full = (beat_cnt == CNT_W'(BURST - 1));

   // AND-OR steer: zero when no grant, din of the winner otherwise. It follows
   // gnt, not req, so a source abandoning its burst still drives the bus that cycle.
   always_comb begin
      out_data = '0;
      for (int k = 0; k < NPORT; k++) begin
         out_data = out_data | (din[k*DW +: DW] & {DW{gnt[k]}});
      end
   end

   always_comb begin
      state_d    = state;
      gnt_d      = gnt;
      busy_d     = busy;
      beat_cnt_d = beat_cnt;
      rr_ptr_d   = rr_ptr;
      win_idx_d  = win_idx;
      end_grant  = 1'b0;

      case (state)
         ST_IDLE: begin
            if (|req) begin
               state_d    = ST_GRANT;
               gnt_d      = pick_onehot;
               win_idx_d  = pick_idx;
               beat_cnt_d = '0;
               busy_d     = 1'b1;
            end
         end

         ST_GRANT: begin
            // A dropped request abandons the burst; no beat is counted for it.
            // last and a full burst on the same beat give one end, not two.
            if (!grant_req) begin
               end_grant = 1'b1;
            end else if (beat) begin
               if (grant_last || burst_full) begin
                  end_grant = 1'b1;
               end else begin
                  beat_cnt_d = beat_cnt + 1'b1;
               end
            end

            if (end_grant) begin
               state_d    = ST_GAP;
               gnt_d      = '0;
               beat_cnt_d = '0;
               busy_d     = 1'b1;
               if (!FIXED) begin
                  rr_ptr_d = next_ptr(win_idx);
               end
            end
         end

         ST_GAP: begin
            // Single turnaround cycle: bus idle but still reported busy.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         gnt      <= '0;
         busy     <= 1'b0;
         beat_cnt <= '0;
         rr_ptr   <= '0;
         win_idx  <= '0;
      end else begin
         state    <= state_d;
         gnt      <= gnt_d;
         busy     <= busy_d;
         beat_cnt <= beat_cnt_d;
         rr_ptr   <= rr_ptr_d;
         win_idx  <= win_idx_d;
      end
   end

endmodule

// File: tb/tb_mux6_bus_arbiter.sv
// Bench for mux6_bus_arbiter: three instances (round-robin BURST=4, fixed
// priority BURST=4, round-robin BURST=1) share one stimulus and one model.
module tb_mux6_bus_arbiter;

   localparam int DW = 4;
   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  req;
   logic [5:0]  last;
   logic [23:0] din;
   logic        out_ready;

   logic [5:0]    gnt_rr, gnt_fp, gnt_b1;
   logic [DW-1:0] data_rr, data_fp, data_b1;
   logic          valid_rr, valid_fp, valid_b1;
   logic          busy_rr, busy_fp, busy_b1;

   logic [NI-1:0][5:0]    gnt_v;
   logic [NI-1:0][DW-1:0] data_v;
   logic [NI-1:0]         valid_v;
   logic [NI-1:0]         busy_v;

   assign gnt_v   = {gnt_b1, gnt_fp, gnt_rr};
   assign data_v  = {data_b1, data_fp, data_rr};
   assign valid_v = {valid_b1, valid_fp, valid_rr};
   assign busy_v  = {busy_b1, busy_fp, busy_rr};

   always #5 clk = ~clk;

   mux6_bus_arbiter #(.DW(DW), .BURST(4), .PRIO_MODE(0)) u_rr (
      .clk(clk), .rst_n(rst_n), .req(req), .last(last), .din(din),
      .gnt(gnt_rr), .out_data(data_rr), .out_valid(valid_rr),
      .out_ready(out_ready), .busy(busy_rr));

   mux6_bus_arbiter #(.DW(DW), .BURST(4), .PRIO_MODE(1)) u_fp (
      .clk(clk), .rst_n(rst_n), .req(req), .last(last), .din(din),
      .gnt(gnt_fp), .out_data(data_fp), .out_valid(valid_fp),
      .out_ready(out_ready), .busy(busy_fp));

   mux6_bus_arbiter #(.DW(DW), .BURST(1), .PRIO_MODE(0)) u_b1 (
      .clk(clk), .rst_n(rst_n), .req(req), .last(last), .din(din),
      .gnt(gnt_b1), .out_data(data_b1), .out_valid(valid_b1),
      .out_ready(out_ready), .busy(busy_b1));

   // ---------------- behavioural model ----------------
   // owner = granted port or -1; gap = turnaround cycle pending;
   // beats = beats accepted in the current grant; ptr = next RR start port.
   int m_owner [NI];
   int m_beats [NI];
   bit m_gap   [NI];
   int m_ptr   [NI];
   int m_burst [NI];
   bit m_prio  [NI];

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         m_owner[i] = -1;
         m_beats[i] = 0;
         m_gap[i]   = 1'b0;
         m_ptr[i]   = 0;
      end
   endtask

   // Applied at each rising edge with the inputs that were present before it.
   task automatic model_update();
      int start;
      int p;
      int w;
      bit fin;
      for (int i = 0; i < NI; i++) begin
         if (!rst_n) begin
            m_owner[i] = -1; m_beats[i] = 0; m_gap[i] = 1'b0; m_ptr[i] = 0;
         end else if (m_gap[i]) begin
            m_gap[i] = 1'b0;
         end else if (m_owner[i] < 0) begin
            if (req != 6'd0) begin
               start = m_prio[i] ? 0 : m_ptr[i];
               for (int k = 0; k < 6; k++) begin
                  p = (start + k) % 6;
                  if (m_owner[i] < 0 && req[p]) m_owner[i] = p;
               end
               m_beats[i] = 0;
            end
         end else begin
            w   = m_owner[i];
            fin = 1'b0;
            if (!req[w]) fin = 1'b1;
            else if (out_ready) begin
               m_beats[i]++;
               if (last[w] || m_beats[i] >= m_burst[i]) fin = 1'b1;
            end
            if (fin) begin
               m_owner[i] = -1;
               m_gap[i]   = 1'b1;
               if (!m_prio[i]) m_ptr[i] = (w + 1) % 6;
            end
         end
      end
   endtask

   function automatic int exp_gnt(int i);
      return (m_owner[i] < 0) ? 0 : (1 << m_owner[i]);
   endfunction

   function automatic int exp_valid(int i);
      return (m_owner[i] < 0) ? 0 : int'(req[m_owner[i]]);
   endfunction

   function automatic int exp_data(int i);
      return (m_owner[i] < 0) ? 0 : int'(din[m_owner[i]*DW +: DW]);
   endfunction

   function automatic int exp_busy(int i);
      return (m_owner[i] >= 0 || m_gap[i]) ? 1 : 0;
   endfunction

   function automatic int oh_idx(logic [5:0] v);
      for (int k = 0; k < 6; k++) if (v[k]) return k;
      return -1;
   endfunction

   // Single compare process: every instance, every falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < NI; i++) begin
            check($sformatf("i%0d_gnt", i),   int'(gnt_v[i]),   exp_gnt(i));
            check($sformatf("i%0d_valid", i), int'(valid_v[i]), exp_valid(i));
            check($sformatf("i%0d_data", i),  int'(data_v[i]),  exp_data(i));
            check($sformatf("i%0d_busy", i),  int'(busy_v[i]),  exp_busy(i));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   // ---------------- stimulus ----------------
   int seq_rr[$];
   int seq_fp[$];
   logic [5:0] prev_rr, prev_fp;
   int e2[4];
   int beats4, seg4, first_fp;

   initial begin
      m_burst = '{4, 4, 1};
      m_prio  = '{1'b0, 1'b1, 1'b0};
      rst_n = 1'b0; req = '0; last = '0; din = '0; out_ready = 1'b0;
      model_reset();
      chk_en = 1'b1;

      // Reset values
      tick(); tick();
      #3;
      check("rst_gnt", int'(gnt_rr), 0);
      check("rst_busy", int'(busy_rr), 0);
      check("rst_valid", int'(valid_rr), 0);
      check("rst_data", int'(data_rr), 0);
      tick(); rst_n = 1'b1;

      // Port 0 alone, two beats of 4'hA, last on the second
      tick(); req = 6'b000001; din = 24'h00000A; last = '0; out_ready = 1'b1;
      #3 check("t1_gnt_same_cycle", int'(gnt_rr), 0);
      tick(); #3;
      check("t1_gnt", int'(gnt_rr), 6'b000001);
      check("t1_beat1", int'(data_rr), 4'hA);
      check("t1_valid1", int'(valid_rr), 1);
      tick(); last = 6'b000001; #3;
      check("t1_gnt_beat2", int'(gnt_rr), 6'b000001);
      check("t1_beat2", int'(data_rr), 4'hA);
      tick(); req = '0; last = '0; #3;
      check("t1_gap_gnt", int'(gnt_rr), 0);
      check("t1_gap_busy", int'(busy_rr), 1);
      tick(); #3;
      check("t1_idle_busy", int'(busy_rr), 0);

      // Ports 0 and 5 held, last every beat: RR alternates 5,0,5,0 (ptr=1)
      req = 6'b100001; last = 6'b100001; din = 24'h50000A;
      prev_rr = gnt_rr; prev_fp = gnt_fp;
      seq_rr.delete(); seq_fp.delete();
      for (int c = 0; c < 14; c++) begin
         tick(); #3;
         if (gnt_rr != 0 && prev_rr == 0) seq_rr.push_back(oh_idx(gnt_rr));
         if (gnt_fp != 0 && prev_fp == 0) seq_fp.push_back(oh_idx(gnt_fp));
         prev_rr = gnt_rr; prev_fp = gnt_fp;
      end
      e2 = '{5, 0, 5, 0};
      check("t2_rr_count", int'(seq_rr.size() >= 4), 1);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("t2_rr_grant%0d", k), (k < seq_rr.size()) ? seq_rr[k] : -1, e2[k]);
         check($sformatf("t2_fp_grant%0d", k), (k < seq_fp.size()) ? seq_fp[k] : -1, 0);
      end

      // Fixed priority, ports 1..5: port 1 always wins, port 2 after req1 drops
      req = '0; last = '0;
      repeat (4) tick();
      req = 6'b111110; last = 6'b111110; din = 24'h654321;
      prev_fp = gnt_fp; seq_fp.delete();
      for (int c = 0; c < 12; c++) begin
         tick(); #3;
         if (gnt_fp != 0 && prev_fp == 0) seq_fp.push_back(oh_idx(gnt_fp));
         prev_fp = gnt_fp;
      end
      check("t3_fp_count", int'(seq_fp.size() >= 3), 1);
      foreach (seq_fp[k]) check($sformatf("t3_fp_grant%0d", k), seq_fp[k], 1);
      req = 6'b111100; last = 6'b111100;
      first_fp = -1;
      for (int c = 0; c < 8; c++) begin
         tick(); #3;
         if (first_fp < 0 && gnt_fp != 0 && prev_fp == 0) first_fp = oh_idx(gnt_fp);
         prev_fp = gnt_fp;
      end
      check("t3_fp_after_drop", first_fp, 2);

      // Port 3 without last: 4 beats even with a 3-cycle out_ready stall
      req = '0; last = '0;
      repeat (4) tick();
      req = 6'b001000; din = 24'h00B000; out_ready = 1'b1;
      beats4 = 0; seg4 = 0;
      for (int c = 0; c < 16; c++) begin
         tick();
         out_ready = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
         #3;
         if (gnt_rr == 6'b001000 && seg4 != 2) begin
            seg4 = 1;
            if (valid_rr && out_ready) beats4++;
         end else if (seg4 == 1) seg4 = 2;
      end
      check("t4_beats", beats4, 4);
      check("t4_gnt_dropped", seg4, 2);

      // Port 2 drops req after one beat: abandon, gap, pointer moves to 3
      req = '0;
      repeat (4) tick();
      out_ready = 1'b1; req = 6'b000100; din = 24'h000C00;
      tick(); #3;
      check("t5_gnt", int'(gnt_rr), 6'b000100);
      tick(); req = '0; #3;
      check("t5_no_beat", int'(valid_rr), 0);
      tick(); #3;
      check("t5_gap_gnt", int'(gnt_rr), 0);
      check("t5_gap_busy", int'(busy_rr), 1);
      req = 6'b100001; din = 24'hD0000E;
      tick(); tick(); #3;
      check("t5_ptr3_win5", int'(gnt_rr), 6'b100000);

      // Asynchronous reset mid-burst, then pointer back at 0
      rst_n = 1'b0; model_reset();
      #1;
      check("t6_gnt", int'(gnt_rr), 0);
      check("t6_valid", int'(valid_rr), 0);
      check("t6_busy", int'(busy_rr), 0);
      tick(); tick(); rst_n = 1'b1;
      tick(); #3;
      check("t6_ptr0_win0", int'(gnt_rr), 6'b000001);

      // Randomised traffic against the model
      for (int c = 0; c < 3000; c++) begin
         tick();
         for (int b = 0; b < 6; b++) if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
         last      = 6'($urandom) & 6'($urandom);
         din       = 24'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) begin
            #3;
            rst_n = 1'b0; model_reset();
            tick();
            rst_n = 1'b1;
         end
      end

      tick();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
